// File: rtl/sdp_hls_prelu_pipe.sv
// Multi-lane PReLU datapath: NUM_CH signed lanes per beat in bypass/ReLU/PReLU mode,
// two register stages with valid/ready flow control and a saturating sat-event counter.
module sdp_hls_prelu_pipe #(
  parameter int NUM_CH      = 4,
  parameter int IN_WIDTH    = 32,
  parameter int OP_WIDTH    = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  input  logic [1:0]                    cfg_mode,
  input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
  input  logic                          cfg_sat_clr,
  input  logic                          in_pvld,
  output logic                          in_prdy,
  input  logic [NUM_CH*IN_WIDTH-1:0]    in_data,
  input  logic [NUM_CH*OP_WIDTH-1:0]    in_op,
  output logic                          out_pvld,
  input  logic                          out_prdy,
  output logic [NUM_CH*OUT_WIDTH-1:0]   out_data,
  output logic [31:0]                   sat_cnt
);

  localparam int PW = IN_WIDTH + OP_WIDTH;
  localparam int EW = PW + 1;
  localparam int CW = $clog2(NUM_CH + 1);
  localparam logic [1:0] MODE_RELU  = 2'd1;
  localparam logic [1:0] MODE_PRELU = 2'd2;
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Any product magnitude is below 2^(PW-1), so once the shift reaches PW the
  // rounded result is always 0 and the wide add can be skipped.
  function automatic logic signed [EW-1:0] round_shift(input logic signed [PW-1:0] p,
                                                       input logic [SHIFT_WIDTH-1:0] sh);
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    ext = {p[PW-1], p};
    rnd = '0;
    if (32'(sh) >= PW) begin
      round_shift = '0;
    end else begin
      if (sh != '0) rnd = {{(EW-1){1'b0}}, 1'b1} << (sh - 1'b1);
      round_shift = (ext + rnd) >>> sh;
    end
  endfunction

  function automatic logic sat_hit(input logic signed [EW-1:0] v);
    sat_hit = (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat_val(input logic signed [EW-1:0] v);
    if (v > SAT_MAX)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (v < SAT_MIN) sat_val = SAT_MIN[OUT_WIDTH-1:0];
    else                  sat_val = v[OUT_WIDTH-1:0];
  endfunction

  logic                        s1_vld_q, s2_vld_q, s1_rdy;
  logic signed [IN_WIDTH-1:0]  lane_x  [NUM_CH];
  logic signed [OP_WIDTH-1:0]  lane_op [NUM_CH];
  logic signed [PW-1:0]        s1_val_d [NUM_CH];
  logic signed [PW-1:0]        s1_val_q [NUM_CH];
  logic [NUM_CH-1:0]           s1_mul_d, s1_mul_q;
  logic [SHIFT_WIDTH-1:0]      s1_shift_q;
  logic signed [EW-1:0]        s2_pre [NUM_CH];
  logic [NUM_CH-1:0]           s2_sat;
  logic [NUM_CH*OUT_WIDTH-1:0] out_data_d, out_data_q;
  logic [CW-1:0]               s2_nsat_d, s2_nsat_q;
  logic [31:0]                 sat_cnt_q;
  logic [32:0]                 sat_sum;

  assign s1_rdy   = !s2_vld_q || out_prdy;
  assign in_prdy  = !s1_vld_q || s1_rdy;
  assign out_pvld = s2_vld_q;
  assign out_data = out_data_q;
  assign sat_cnt  = sat_cnt_q;

  // Stage 1: lane select and multiply
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lane_x[i]   = in_data[i*IN_WIDTH +: IN_WIDTH];
      lane_op[i]  = in_op[i*OP_WIDTH +: OP_WIDTH];
      s1_val_d[i] = PW'(lane_x[i]);
      s1_mul_d[i] = 1'b0;
      if (lane_x[i][IN_WIDTH-1]) begin
        if (cfg_mode == MODE_PRELU) begin
          s1_val_d[i] = PW'(lane_x[i]) * PW'(lane_op[i]);
          s1_mul_d[i] = 1'b1;
        end else if (cfg_mode == MODE_RELU) begin
          s1_val_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      if (in_prdy) s1_vld_q <= in_pvld;
      if (s1_rdy)  s2_vld_q <= s1_vld_q;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (in_prdy && in_pvld) begin
      s1_val_q   <= s1_val_d;
      s1_mul_q   <= s1_mul_d;
      s1_shift_q <= cfg_shift;
    end
  end

  // Stage 2: round/shift, saturate, count clamped lanes
  always_comb begin
    out_data_d = '0;
    s2_nsat_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s2_pre[i] = s1_mul_q[i] ? round_shift(s1_val_q[i], s1_shift_q)
                              : {s1_val_q[i][PW-1], s1_val_q[i]};
      s2_sat[i] = sat_hit(s2_pre[i]);
      out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = sat_val(s2_pre[i]);
      s2_nsat_d = s2_nsat_d + CW'(s2_sat[i]);
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      out_data_q <= '0;
      s2_nsat_q  <= '0;
    end else if (s1_rdy && s1_vld_q) begin
      out_data_q <= out_data_d;
      s2_nsat_q  <= s2_nsat_d;
    end
  end

  // Counted on output transfer so a stalled beat contributes once
  assign sat_sum = {1'b0, sat_cnt_q} + 33'(s2_nsat_q);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      sat_cnt_q <= '0;
    end else if (cfg_sat_clr) begin
      sat_cnt_q <= '0;
    end else if (s2_vld_q && out_prdy) begin
      sat_cnt_q <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
    end
  end

endmodule

// File: tb/tb_sdp_hls_prelu_pipe.sv
// Directed bench for sdp_hls_prelu_pipe: modes, rounding/shift edges, saturation
// counting, stall/backpressure ordering and mid-stream reset.
module tb_sdp_hls_prelu_pipe;

  logic          clk, rst;
  logic [1:0]    cfg_mode;
  logic [5:0]    cfg_shift;
  logic          cfg_sat_clr;
  logic          in_pvld, in_prdy, out_pvld, out_prdy;
  logic [127:0]  in_data, out_data;
  logic [63:0]   in_op;
  logic [31:0]   sat_cnt;

  int checks = 0;
  int errors = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  sdp_hls_prelu_pipe dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_mode       (cfg_mode),
    .cfg_shift      (cfg_shift),
    .cfg_sat_clr    (cfg_sat_clr),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy),
    .in_data        (in_data),
    .in_op          (in_op),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data),
    .sat_cnt        (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_one(input string tag, input logic [1:0] m, input logic [5:0] sh,
                          input logic [127:0] d, input logic [63:0] o, input logic [127:0] e);
    cfg_mode = m; cfg_shift = sh; in_data = d; in_op = o; in_pvld = 1'b1;
    check({tag, ".rdy"}, in_prdy, 1);
    @(posedge clk); #1;
    in_pvld = 1'b0; cfg_mode = 2'd0; cfg_shift = ~sh;
    check({tag, ".lat1"}, out_pvld, 0);
    @(posedge clk); #1;
    check({tag, ".vld"}, out_pvld, 1);
    check({tag, ".data"}, out_data, e);
    @(posedge clk); #1;
    check({tag, ".drain"}, out_pvld, 0);
  endtask

  function automatic logic [31:0] model_lane(input logic [1:0] m, input logic [5:0] sh,
                                             input logic [31:0] x, input logic [15:0] op,
                                             output bit sat);
    longint xs, os, v;
    xs = $signed(x);
    os = $signed(op);
    if (m == 2'd2 && xs < 0) begin
      v = xs * os;
      if (sh != 6'd0) v = (v + (longint'(1) <<< (sh - 6'd1))) >>> sh;
    end else if (m == 2'd1 && xs < 0) begin
      v = 0;
    end else begin
      v = xs;
    end
    sat = 1'b0;
    if (v > SMAX) begin v = SMAX; sat = 1'b1; end
    else if (v < SMIN) begin v = SMIN; sat = 1'b1; end
    return v[31:0];
  endfunction

  logic [127:0] pend_exp;
  int           pend_sat;

  task automatic gen_beat();
    logic [127:0] d, e;
    logic [63:0]  o;
    logic [1:0]   m;
    logic [5:0]   sh;
    logic [31:0]  x;
    logic [15:0]  op;
    bit           s;
    int           ns;
    m  = 2'($urandom_range(0, 3));
    sh = 6'($urandom_range(0, 24));
    if ($urandom_range(0, 7) == 0) sh = 6'd63;
    ns = 0;
    for (int i = 0; i < 4; i++) begin
      x  = $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'h8000_0000;
      op = 16'($urandom);
      d[i*32 +: 32] = x;
      o[i*16 +: 16] = op;
      e[i*32 +: 32] = model_lane(m, sh, x, op, s);
      ns += int'(s);
    end
    cfg_mode = m; cfg_shift = sh; in_data = d; in_op = o;
    pend_exp = e; pend_sat = ns;
  endtask

  logic [127:0] sat_d, sat_e, b_d, c_d;
  logic [63:0]  sat_o;
  logic [127:0] exp_q[$];
  int sent, got, occ, cyc, sat_model;
  bit acc, emi;

  initial begin
    rst = 1'b0; cfg_mode = 2'd0; cfg_shift = 6'd0; cfg_sat_clr = 1'b0;
    in_pvld = 1'b0; in_data = '0; in_op = '0; out_prdy = 1'b1;
    sat_d = {4{32'h8000_0000}};
    sat_o = {16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    sat_e = {32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    b_d   = {32'd4, 32'd3, 32'd2, 32'd1};
    c_d   = {32'hFFFF_FFF8, 32'd7, 32'd6, 32'd5};

    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("reset.out_pvld", out_pvld, 0);
    check("reset.out_data", out_data, 0);
    check("reset.sat_cnt", sat_cnt, 0);
    rst = 1'b0; #1;
    check("reset.in_prdy", in_prdy, 1);
    @(posedge clk); #1;

    send_one("prelu_s4", 2'd2, 6'd4,
             {32'hFFFF_FFFF, 32'h0, 32'd50, 32'hFFFF_FF9C}, {16'hFFFF, 16'd5, 16'd7, 16'd3},
             {32'h0, 32'h0, 32'h32, 32'hFFFF_FFED});
    send_one("relu", 2'd1, 6'd0,
             {32'h7, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF}, {4{16'h0003}},
             {32'h7, 32'h0, 32'h7FFF_FFFF, 32'h0});
    send_one("shift63", 2'd2, 6'd63,
             {32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
             {16'h7FFF, 16'h8000, 16'hFFFB, 16'h0001}, 128'h0);
    send_one("shift1", 2'd2, 6'd1,
             {32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
             {16'h1, 16'h1, 16'hFFFD, 16'h3},
             {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF});
    send_one("shift20", 2'd2, 6'd20,
             {32'hFFFF_FFF9, 32'h4D2, 32'h8000_0000, 32'h8000_0000},
             {16'h2, 16'h1, 16'h7FFF, 16'h8000},
             {32'h0, 32'h4D2, 32'hFC00_0800, 32'h0400_0000});

    // back-to-back beats with per-beat mode: relu, bypass, reserved
    cfg_mode = 2'd1; in_data = {32'h7, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    in_op = {4{16'h0003}}; in_pvld = 1'b1;
    @(posedge clk); #1;
    cfg_mode = 2'd0;
    @(posedge clk); #1;
    cfg_mode = 2'd3;
    check("b2b.relu", out_data, {32'h7, 32'h0, 32'h7FFF_FFFF, 32'h0});
    @(posedge clk); #1;
    in_pvld = 1'b0;
    check("b2b.bypass", out_data, {32'h7, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF});
    @(posedge clk); #1;
    check("b2b.reserved", out_data, {32'h7, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF});
    check("b2b.vld", out_pvld, 1);
    @(posedge clk); #1;
    check("b2b.drain", out_pvld, 0);

    check("sat.cnt0", sat_cnt, 0);
    send_one("sat1", 2'd2, 6'd0, sat_d, sat_o, sat_e);
    check("sat.cnt4", sat_cnt, 4);
    send_one("sat2", 2'd2, 6'd0, sat_d, sat_o, sat_e);
    send_one("sat3", 2'd2, 6'd0, sat_d, sat_o, sat_e);
    check("sat.cnt12", sat_cnt, 12);
    cfg_mode = 2'd2; cfg_shift = 6'd0; in_data = sat_d; in_op = sat_o; in_pvld = 1'b1;
    @(posedge clk); #1;
    in_pvld = 1'b0;
    @(posedge clk); #1;
    check("sat.vld4", out_pvld, 1);
    check("sat.pre_clr", sat_cnt, 12);
    cfg_sat_clr = 1'b1;
    @(posedge clk); #1;
    cfg_sat_clr = 1'b0;
    check("sat.clr_wins", sat_cnt, 0);

    // stall: fill both stages with out_prdy low, then release
    out_prdy = 1'b0;
    cfg_mode = 2'd2; cfg_shift = 6'd0; in_data = sat_d; in_op = sat_o; in_pvld = 1'b1;
    check("stall.rdyA", in_prdy, 1);
    @(posedge clk); #1;
    cfg_mode = 2'd0; in_data = b_d;
    check("stall.rdyB", in_prdy, 1);
    @(posedge clk); #1;
    in_data = c_d;
    check("stall.full", in_prdy, 0);
    check("stall.vld", out_pvld, 1);
    check("stall.dataA", out_data, sat_e);
    repeat (3) @(posedge clk);
    #1;
    check("stall.hold", out_data, sat_e);
    check("stall.rdyhold", in_prdy, 0);
    check("stall.cnt_nocount", sat_cnt, 0);
    out_prdy = 1'b1; #1;
    check("stall.rdyrel", in_prdy, 1);
    @(posedge clk); #1;
    in_pvld = 1'b0;
    check("stall.cnt_once", sat_cnt, 4);
    check("stall.dataB", out_data, b_d);
    @(posedge clk); #1;
    check("stall.dataC", out_data, c_d);
    @(posedge clk); #1;
    check("stall.empty", out_pvld, 0);
    check("stall.cnt_after", sat_cnt, 4);

    // reset with two beats in flight
    cfg_mode = 2'd0; in_data = b_d; in_pvld = 1'b1;
    @(posedge clk); #1;
    in_data = c_d;
    @(posedge clk); #1;
    in_pvld = 1'b0;
    check("rst.inflight", out_pvld, 1);
    #2 rst = 1'b1;
    #1;
    check("rst.out_pvld", out_pvld, 0);
    check("rst.out_data", out_data, 0);
    check("rst.sat_cnt", sat_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("rst.in_prdy", in_prdy, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rst.no_stale", out_pvld, 0);
    end

    // random beats under out_prdy pattern 1,0,0
    sent = 0; got = 0; occ = 0; cyc = 0; sat_model = 0;
    gen_beat();
    in_pvld = 1'b1;
    out_prdy = 1'b1;
    while (got < 100 && cyc < 2000) begin
      @(negedge clk);
      check("rand.in_prdy", in_prdy, (occ == 2 && !out_prdy) ? 1'b0 : 1'b1);
      acc = in_pvld && in_prdy;
      emi = out_pvld && out_prdy;
      if (emi) begin
        if (exp_q.size() == 0) check("rand.unexpected_beat", out_data, 128'hx);
        else check("rand.out_data", out_data, exp_q.pop_front());
      end
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(pend_exp);
        sat_model += pend_sat;
        sent++; occ++;
        if (sent < 100) gen_beat();
        else in_pvld = 1'b0;
      end
      if (emi) begin
        got++; occ--;
      end
      cyc++;
      out_prdy = (cyc % 3 == 0);
    end
    out_prdy = 1'b1;
    check("rand.beats", 128'(got), 128'(100));
    check("rand.leftover", 128'(exp_q.size()), 128'(0));
    check("rand.sat_cnt", sat_cnt, 128'(sat_model));

    cfg_sat_clr = 1'b1;
    @(posedge clk); #1;
    cfg_sat_clr = 1'b0;
    check("clr.alone", sat_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdp_hls_prelu_pipe.md
Name: sdp_hls_prelu_pipe

Overview:
Multi-lane, pipelined successor to the SDP HLS PReLU datapath. Processes NUM_CH signed lanes per beat in bypass, ReLU or PReLU mode. The multiplied path is rounded, right-shifted and saturated to OUT_WIDTH. Sits between the SDP BN/EW operand fetch and the output converter, with a valid/ready pipe interface and a saturation-event counter for perf/debug.

Parameters:
NUM_CH, 4, number of parallel lanes per beat
IN_WIDTH, 32, signed input element width
OP_WIDTH, 16, signed per-lane slope operand width
OUT_WIDTH, 32, signed output element width (must be <= IN_WIDTH+OP_WIDTH)
SHIFT_WIDTH, 6, width of cfg_shift

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rst  input  1  asynchronous, active-high reset
cfg_mode  input  2  0=bypass, 1=relu, 2=prelu, 3=reserved (treated as bypass)
cfg_shift  input  SHIFT_WIDTH  right-shift amount applied to the prelu product
cfg_sat_clr  input  1  one-cycle pulse; clears sat_cnt
in_pvld  input  1  input beat valid
in_prdy  output  1  input beat ready
in_data  input  NUM_CH*IN_WIDTH  lane i at [i*IN_WIDTH +: IN_WIDTH]
in_op  input  NUM_CH*OP_WIDTH  per-lane slope, lane i at [i*OP_WIDTH +: OP_WIDTH]
out_pvld  output  1  output beat valid
out_prdy  input  1  output beat ready
out_data  output  NUM_CH*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH]
sat_cnt  output  32  count of saturated lane results since reset/clear

Behaviour:
- Reset (async, active-high): s1_vld=0, s2_vld=0, out_pvld=0, out_data=0, sat_cnt=0. in_prdy=1 after reset deassert. Beats in flight are discarded.
- Handshake: a transfer occurs on pvld&prdy at a clock edge. in_pvld/in_data/in_op held stable while in_pvld&!in_prdy; out side identical.
- Pipeline, 2 register stages:
  - in_prdy = !s1_vld | s1_rdy; s1_rdy = !s2_vld | out_prdy; out_pvld = s2_vld.
  - Latency: exactly 2 cycles from accept to out_pvld when unstalled. Throughput 1 beat/cycle. No combinational path in_pvld->out_pvld.
- cfg_mode and cfg_shift are captured into stage 1 with each accepted beat and travel with it. A config change affects only beats accepted afterwards.
- Stage 1 per lane, with x=in_data lane and neg=x[IN_WIDTH-1]:
  - bypass, or relu/prelu with !neg: pass x (flag pass).
  - relu & neg: value 0 (flag pass).
  - prelu & neg: p = signed(x)*signed(op), full IN_WIDTH+OP_WIDTH bits (flag mul).
- Stage 2 per lane:
  - mul: r = (p + (cfg_shift!=0 ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift, computed at IN_WIDTH+OP_WIDTH+1 bits (round half up toward +inf). Then saturate to signed OUT_WIDTH range.
  - pass: sign-extend or saturate x to OUT_WIDTH.
  - cfg_shift >= IN_WIDTH+OP_WIDTH: result is 0 for non-negative p, -1 before rounding for negative p; rounding rule still applied.
  - Saturation: values > 2^(OUT_WIDTH-1)-1 clamp to max; values < -2^(OUT_WIDTH-1) clamp to min. Each clamped lane is a sat event.
- sat_cnt: on each output transfer (out_pvld&out_prdy), add the number of saturated lanes in that beat (0..NUM_CH). Saturates at 0xFFFFFFFF, no wrap. cfg_sat_clr in the same cycle as an increment: clear wins, result is 0. Counting happens at output transfer, not at stage-2 load, so a stalled beat is counted once.
- Stall: with out_prdy=0, the pipe fills (2 beats) and then in_prdy=0. out_data/out_pvld are held unchanged while stalled.

Test Plan:
- Reset mid-stream: 2 beats in flight, assert nvdla_core_rst -> out_pvld=0, sat_cnt=0, out_data=0 immediately; in_prdy=1 after release; no stale beat emerges.
- prelu, cfg_shift=4, lane0 x=-100, op=3 -> p=-300, (-300+8)>>>4 = -19 (0xFFFFFFED). Lane1 x=50 -> 50. out_pvld 2 cycles after accept.
- relu, lanes {-1, 0x7FFFFFFF, -2^31, 7} -> {0, 0x7FFFFFFF, 0, 7}. bypass same input -> unchanged. Mode switched between back-to-back beats applies per beat.
- Saturation: prelu, shift=0, x=-2^31, op=-32768 -> 0x7FFFFFFF. All 4 lanes saturate over 3 transferred beats -> sat_cnt=12. cfg_sat_clr coincident with 4th beat transfer -> sat_cnt=0.
- Backpressure: continuous in_pvld=1, out_prdy toggling 1,0,0,1,...; 100 random beats -> output sequence identical to reference model, in order, none dropped or duplicated. in_prdy=0 only when both stages are full and out_prdy=0.
- Shift boundary: cfg_shift=63, p=-1 -> 0; p=+5 -> 0. cfg_shift=1, p=-3 -> -1; p=3 -> 2.
